// File: rtl/hoplite_message_interface_pkg.sv
// Shared packet definitions for the Hoplite node message interface.
// Default field widths, the packet width helper, and the default-width packet
// layout (MSB to LSB: x, y, multicast, done, result, type, mx, my, element).
package hoplite_message_interface_pkg;

  localparam int unsigned COORD_BITS_D           = 1;
  localparam int unsigned MULTICAST_GROUP_BITS_D = 1;
  localparam int unsigned MATRIX_TYPE_BITS_D     = 1;
  localparam int unsigned MATRIX_COORD_BITS_D    = 8;
  localparam int unsigned MATRIX_ELEMENT_BITS_D  = 32;

  // Total packet width for a given set of field widths (done/result are 1 bit each).
  function automatic int unsigned packet_bits(input int unsigned cb, input int unsigned mgb,
                                              input int unsigned mtb, input int unsigned mcb,
                                              input int unsigned meb);
    return 2 * cb + mgb + 2 + mtb + 2 * mcb + meb;
  endfunction

  localparam int unsigned PACKET_BITS_D = packet_bits(COORD_BITS_D, MULTICAST_GROUP_BITS_D,
                                                      MATRIX_TYPE_BITS_D, MATRIX_COORD_BITS_D,
                                                      MATRIX_ELEMENT_BITS_D);

  typedef struct packed {
    logic [COORD_BITS_D-1:0]           x_coord;
    logic [COORD_BITS_D-1:0]           y_coord;
    logic [MULTICAST_GROUP_BITS_D-1:0] multicast_group;
    logic                              done_flag;
    logic                              result_flag;
    logic [MATRIX_TYPE_BITS_D-1:0]     matrix_type;
    logic [MATRIX_COORD_BITS_D-1:0]    matrix_x_coord;
    logic [MATRIX_COORD_BITS_D-1:0]    matrix_y_coord;
    logic [MATRIX_ELEMENT_BITS_D-1:0]  matrix_element;
  } hmi_packet_t;

endpackage

// File: rtl/hoplite_message_interface_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: push_i/din_i write side, pop_i/dout_o read side (dout_o shows the head
// whenever empty_o is low), full_o/empty_o/count_o status from the registered count.
module hoplite_message_interface_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Requests are ignored when they cannot be honoured.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer/count next state; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; contents are only visible while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/hoplite_message_interface.sv
// Node-side interface between a processor's packet registers and a Hoplite router port.
// TX: per-field staging registers (*_in + *_in_valid), packet_complete_in enqueues the
//     assembled packet (same-cycle field writes bypassed), drained via
//     packet_out/packet_out_valid/packet_out_ready; message_out_ready and sticky
//     tx_overflow report TX space and drops.
// RX: packet_in/packet_in_valid/packet_in_ready fill the RX FIFO; the head is shown on
//     the *_out fields with message_in_available/message_in_valid; message_in_read pops.
module hoplite_message_interface
  import hoplite_message_interface_pkg::*;
#(
  parameter int unsigned COORD_BITS           = COORD_BITS_D,
  parameter int unsigned MULTICAST_GROUP_BITS = MULTICAST_GROUP_BITS_D,
  parameter int unsigned MATRIX_TYPE_BITS     = MATRIX_TYPE_BITS_D,
  parameter int unsigned MATRIX_COORD_BITS    = MATRIX_COORD_BITS_D,
  parameter int unsigned MATRIX_ELEMENT_BITS  = MATRIX_ELEMENT_BITS_D,
  parameter int unsigned X_COORD              = 0,
  parameter int unsigned Y_COORD              = 0,
  parameter int unsigned TX_DEPTH             = 4,
  parameter int unsigned RX_DEPTH             = 8,
  localparam int unsigned PACKET_BITS = packet_bits(COORD_BITS, MULTICAST_GROUP_BITS,
                                                    MATRIX_TYPE_BITS, MATRIX_COORD_BITS,
                                                    MATRIX_ELEMENT_BITS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [COORD_BITS-1:0]           x_coord_in,
  input  logic                            x_coord_in_valid,
  input  logic [COORD_BITS-1:0]           y_coord_in,
  input  logic                            y_coord_in_valid,
  input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
  input  logic                            multicast_group_in_valid,
  input  logic                            done_flag_in,
  input  logic                            done_flag_in_valid,
  input  logic                            result_flag_in,
  input  logic                            result_flag_in_valid,
  input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
  input  logic                            matrix_type_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
  input  logic                            matrix_x_coord_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
  input  logic                            matrix_y_coord_in_valid,
  input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
  input  logic                            matrix_element_in_valid,
  input  logic                            packet_complete_in,
  output logic                            message_out_ready,
  output logic                            tx_overflow,
  output logic [PACKET_BITS-1:0]          packet_out,
  output logic                            packet_out_valid,
  input  logic                            packet_out_ready,
  input  logic [PACKET_BITS-1:0]          packet_in,
  input  logic                            packet_in_valid,
  output logic                            packet_in_ready,
  output logic                            message_in_available,
  output logic                            message_in_valid,
  output logic [MULTICAST_GROUP_BITS-1:0] multicast_group_out,
  output logic                            done_flag_out,
  output logic                            result_flag_out,
  output logic [MATRIX_TYPE_BITS-1:0]     matrix_type_out,
  output logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_out,
  output logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_out,
  output logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_out,
  input  logic                            message_in_read
);

  localparam int unsigned TX_CW    = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_CW    = $clog2(RX_DEPTH) + 1;
  localparam int unsigned MY_LSB   = MATRIX_ELEMENT_BITS;
  localparam int unsigned MX_LSB   = MY_LSB + MATRIX_COORD_BITS;
  localparam int unsigned TY_LSB   = MX_LSB + MATRIX_COORD_BITS;
  localparam int unsigned RES_BIT  = TY_LSB + MATRIX_TYPE_BITS;
  localparam int unsigned DONE_BIT = RES_BIT + 1;
  localparam int unsigned MC_LSB   = DONE_BIT + 1;
  localparam int unsigned Y_LSB    = MC_LSB + MULTICAST_GROUP_BITS;
  localparam int unsigned X_LSB    = Y_LSB + COORD_BITS;

  logic [COORD_BITS-1:0]           x_q, x_d, y_q, y_d;
  logic [MULTICAST_GROUP_BITS-1:0] mc_q, mc_d;
  logic                            done_q, done_d, res_q, res_d;
  logic [MATRIX_TYPE_BITS-1:0]     type_q, type_d;
  logic [MATRIX_COORD_BITS-1:0]    mx_q, mx_d, my_q, my_d;
  logic [MATRIX_ELEMENT_BITS-1:0]  el_q, el_d;
  logic                            tx_overflow_q, tx_overflow_d;
  logic                            message_out_ready_q, message_out_ready_d;

  logic [PACKET_BITS-1:0] tx_din, tx_dout, rx_dout, rx_head;
  logic                   tx_push, tx_pop, tx_full, tx_empty;
  logic                   rx_push, rx_pop, rx_full, rx_empty;
  logic [TX_CW-1:0]       tx_count;
  logic [RX_CW-1:0]       rx_count;
  logic                   dest_match, is_mcast;

  // Staging next state; the _d values double as the same-cycle bypass for enqueue.
  always_comb begin
    x_d    = x_coord_in_valid        ? x_coord_in         : x_q;
    y_d    = y_coord_in_valid        ? y_coord_in         : y_q;
    mc_d   = multicast_group_in_valid ? multicast_group_in : mc_q;
    done_d = done_flag_in_valid      ? done_flag_in       : done_q;
    res_d  = result_flag_in_valid    ? result_flag_in     : res_q;
    type_d = matrix_type_in_valid    ? matrix_type_in     : type_q;
    mx_d   = matrix_x_coord_in_valid ? matrix_x_coord_in  : mx_q;
    my_d   = matrix_y_coord_in_valid ? matrix_y_coord_in  : my_q;
    el_d   = matrix_element_in_valid ? matrix_element_in  : el_q;
  end

  // Drop detection is against the registered full flag, so a same-cycle pop never makes room.
  always_comb begin
    tx_overflow_d       = tx_overflow_q | (packet_complete_in & tx_full);
    message_out_ready_d = (tx_count < TX_CW'(TX_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q                 <= '0;
      y_q                 <= '0;
      mc_q                <= '0;
      done_q              <= 1'b0;
      res_q               <= 1'b0;
      type_q              <= '0;
      mx_q                <= '0;
      my_q                <= '0;
      el_q                <= '0;
      tx_overflow_q       <= 1'b0;
      message_out_ready_q <= 1'b1;
    end else begin
      x_q                 <= x_d;
      y_q                 <= y_d;
      mc_q                <= mc_d;
      done_q              <= done_d;
      res_q               <= res_d;
      type_q              <= type_d;
      mx_q                <= mx_d;
      my_q                <= my_d;
      el_q                <= el_d;
      tx_overflow_q       <= tx_overflow_d;
      message_out_ready_q <= message_out_ready_d;
    end
  end

  assign tx_overflow       = tx_overflow_q;
  assign message_out_ready = message_out_ready_q;

  // TX path
  assign tx_din  = {x_d, y_d, mc_d, done_d, res_d, type_d, mx_d, my_d, el_d};
  assign tx_push = packet_complete_in && !tx_full;
  assign tx_pop  = packet_out_valid && packet_out_ready;

  hoplite_message_interface_sync_fifo #(
    .WIDTH (PACKET_BITS),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tx_push),
    .din_i   (tx_din),
    .pop_i   (tx_pop),
    .dout_o  (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  assign packet_out_valid = !tx_empty;
  assign packet_out       = tx_empty ? '0 : tx_dout;

  // RX path
  assign packet_in_ready = !rx_full;
  assign rx_push         = packet_in_valid && !rx_full;
  assign rx_pop          = message_in_read && !rx_empty;

  hoplite_message_interface_sync_fifo #(
    .WIDTH (PACKET_BITS),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push),
    .din_i   (packet_in),
    .pop_i   (rx_pop),
    .dout_o  (rx_dout),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  // Head fields read as zero while nothing is buffered.
  assign rx_head              = rx_empty ? '0 : rx_dout;
  assign message_in_available = (rx_count != '0);

  assign dest_match = (rx_head[X_LSB +: COORD_BITS] == COORD_BITS'(X_COORD)) &&
                      (rx_head[Y_LSB +: COORD_BITS] == COORD_BITS'(Y_COORD));
  assign is_mcast   = |rx_head[MC_LSB +: MULTICAST_GROUP_BITS];
  assign message_in_valid = message_in_available && (dest_match || is_mcast);

  assign multicast_group_out = rx_head[MC_LSB +: MULTICAST_GROUP_BITS];
  assign done_flag_out       = rx_head[DONE_BIT];
  assign result_flag_out     = rx_head[RES_BIT];
  assign matrix_type_out     = rx_head[TY_LSB +: MATRIX_TYPE_BITS];
  assign matrix_x_coord_out  = rx_head[MX_LSB +: MATRIX_COORD_BITS];
  assign matrix_y_coord_out  = rx_head[MY_LSB +: MATRIX_COORD_BITS];
  assign matrix_element_out  = rx_head[0 +: MATRIX_ELEMENT_BITS];

endmodule
